// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window fetch path.
// Pure declarations; no latency.
// No flow control here.
package sobel_pkg;

  localparam int PIX_W        = 16;
  localparam int WORD_W       = 64;
  localparam int PIX_PER_WORD = 4;
  localparam int DEFAULT_AW   = 22;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sobel_beat_counter.sv
// Modulo-BEATS shift beat counter with synchronous clear and enable.
// last_o is combinational from the count; the count updates one cycle after en.
// Holding en low (stall) freezes the count, so the current beat repeats.
module sobel_beat_counter #(
  parameter int BEATS = 3,
  localparam int BW   = $clog2(BEATS + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic last_o
);

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  logic [BW-1:0] beat_q;
  logic [BW-1:0] beat_d;

  assign last_o = (beat_q == LAST_BEAT);

  // Next beat: clear wins, then wrap on the last beat, otherwise count up.
  always_comb begin
    beat_d = beat_q;
    if (clr) begin
      beat_d = '0;
    end else if (en) begin
      beat_d = last_o ? '0 : beat_q + BW'(1);
    end
  end

  // Beat register.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

endmodule

// File: rtl/sobel_fetch_sequencer.sv
// Walks a word range, one read per word, then load + BEATS shift pulses per word.
// First read request 1 cycle after start; zero-wait word costs 1 + BEATS cycles.
// Waits indefinitely for rd_valid_i; stall_i freezes only the shift beats.
module sobel_fetch_sequencer
  import sobel_pkg::*;
#(
  parameter int START_ADDR    = 0,
  parameter int END_ADDR      = 4194303,
  parameter int WORDS_PER_ROW = 512,
  parameter int BEATS         = 3,
  parameter int AW            = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic          stall_i,
  output logic          rd_req_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic          rd_valid_i,
  output logic          load_o,
  output logic          shift_o,
  output logic          window_valid_o,
  output logic          row_start_o,
  output logic          busy_o,
  output logic          frame_done_o
);

  localparam int            CW       = $clog2(WORDS_PER_ROW);
  localparam logic [AW-1:0] START_A  = AW'(START_ADDR);
  localparam logic [AW-1:0] END_A    = AW'(END_ADDR);
  localparam logic [CW-1:0] COL_LAST = CW'(WORDS_PER_ROW - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] col_q, col_d;

  logic beat_clr;
  logic beat_en;
  logic beat_last;

  sobel_beat_counter #(
    .BEATS (BEATS)
  ) u_beat (
    .clk    (clk),
    .reset  (reset),
    .clr    (beat_clr),
    .en     (beat_en),
    .last_o (beat_last)
  );

  assign rd_addr_o = addr_q;

  // The first word of a row only primes the 128-bit window, so its shifts are never valid.
  assign window_valid_o = shift_o && (col_q != '0);

  // Next-state and output decode; rd_valid_i is only honoured while fetching.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    col_d        = col_q;
    rd_req_o     = 1'b0;
    load_o       = 1'b0;
    shift_o      = 1'b0;
    row_start_o  = 1'b0;
    busy_o       = 1'b0;
    frame_done_o = 1'b0;
    beat_clr     = 1'b1;
    beat_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_FETCH;
          addr_d  = START_A;
          col_d   = '0;
        end
      end

      ST_FETCH: begin
        busy_o   = 1'b1;
        rd_req_o = 1'b1;
        if (rd_valid_i) begin
          load_o      = 1'b1;
          row_start_o = (col_q == '0);
          state_d     = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        busy_o   = 1'b1;
        beat_clr = 1'b0;
        beat_en  = !stall_i;
        shift_o  = !stall_i;
        // A stall on the final beat holds everything, so that beat repeats.
        if (!stall_i && beat_last) begin
          if (addr_q == END_A) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + AW'(1);
            col_d   = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
            state_d = ST_FETCH;
          end
        end
      end

      ST_DONE: begin
        frame_done_o = 1'b1;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, address and column registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= START_A;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
    end
  end

endmodule

// File: tb/tb_sobel_fetch_sequencer.sv
// Scoreboard bench for sobel_fetch_sequencer: two instances (4-word frame with
// 2-word rows, and a single-word frame), a responding memory model, and a
// monitor that pops expected events whenever the DUT shows load/shift/done.
module tb_sobel_fetch_sequencer;

  localparam int AW    = 22;
  localparam int BEATS = 3;
  localparam int NI    = 2;
  localparam int K_LOAD  = 0;
  localparam int K_SHIFT = 1;
  localparam int K_DONE  = 2;

  int start_cfg [NI] = '{0, 5};
  int end_cfg   [NI] = '{3, 5};
  int wpr_cfg   [NI] = '{2, 4};

  logic clk = 1'b0;
  logic [NI-1:0] reset_s, start_s, stall_s, rdv_s;
  logic [NI-1:0] req_s, load_s, shift_s, win_s, row_s, busy_s, done_s;
  logic [NI-1:0][AW-1:0] addr_s;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sobel_fetch_sequencer #(
    .START_ADDR(0), .END_ADDR(3), .WORDS_PER_ROW(2), .BEATS(BEATS), .AW(AW)
  ) dut_a (
    .clk(clk), .reset(reset_s[0]), .start_i(start_s[0]), .stall_i(stall_s[0]),
    .rd_req_o(req_s[0]), .rd_addr_o(addr_s[0]), .rd_valid_i(rdv_s[0]),
    .load_o(load_s[0]), .shift_o(shift_s[0]), .window_valid_o(win_s[0]),
    .row_start_o(row_s[0]), .busy_o(busy_s[0]), .frame_done_o(done_s[0])
  );

  sobel_fetch_sequencer #(
    .START_ADDR(5), .END_ADDR(5), .WORDS_PER_ROW(4), .BEATS(BEATS), .AW(AW)
  ) dut_b (
    .clk(clk), .reset(reset_s[1]), .start_i(start_s[1]), .stall_i(stall_s[1]),
    .rd_req_o(req_s[1]), .rd_addr_o(addr_s[1]), .rd_valid_i(rdv_s[1]),
    .load_o(load_s[1]), .shift_o(shift_s[1]), .window_valid_o(win_s[1]),
    .row_start_o(row_s[1]), .busy_o(busy_s[1]), .frame_done_o(done_s[1])
  );

  typedef struct {
    int            id;
    int            kind;
    logic [AW-1:0] addr;
    bit            row;
    bit            win;
  } ev_t;

  ev_t exp_q[$];

  // Per-instance model and stimulus state
  int lat [NI], wait_cnt [NI], pend_shift [NI], stall_cnt [NI], t_start [NI];
  int req_run [NI], words_loaded [NI], stall_prob [NI], stall_run [NI];
  int hold_addr [NI], rst_cnt [NI];
  bit spur_en [NI], stall_w0 [NI], go_req [NI], start_pending [NI];
  bit kick_rdv [NI], just_reset [NI], req_prev [NI];
  logic [AW-1:0] addr_prev [NI];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string nm, longint act, longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int front_idx(int id);
    foreach (exp_q[k]) if (exp_q[k].id == id) return k;
    return -1;
  endfunction

  function automatic bit model_idle(int id);
    return front_idx(id) < 0;
  endfunction

  // Reference model: the whole frame's event list from the address range.
  task automatic push_frame(int id);
    ev_t ev;
    int n = end_cfg[id] - start_cfg[id] + 1;
    ev.id = id;
    for (int w = 0; w < n; w++) begin
      ev.kind = K_LOAD; ev.addr = AW'(start_cfg[id] + w);
      ev.row  = ((w % wpr_cfg[id]) == 0); ev.win = 1'b0;
      exp_q.push_back(ev);
      for (int b = 0; b < BEATS; b++) begin
        ev.kind = K_SHIFT; ev.row = 1'b0; ev.win = ((w % wpr_cfg[id]) != 0);
        exp_q.push_back(ev);
      end
    end
    ev.kind = K_DONE; ev.row = 1'b0; ev.win = 1'b0;
    exp_q.push_back(ev);
    t_start[id] = cyc; stall_cnt[id] = 0; words_loaded[id] = 0;
    pend_shift[id] = 0; stall_run[id] = 0;
  endtask

  task automatic clear_model(int i);
    for (int k = exp_q.size() - 1; k >= 0; k--)
      if (exp_q[k].id == i) exp_q.delete(k);
    pend_shift[i] = 0; start_pending[i] = 0; go_req[i] = 0;
    wait_cnt[i] = 0; req_run[i] = 0; req_prev[i] = 0;
  endtask

  // Drive one instance's inputs for the coming cycle.
  task automatic drive(int i);
    if (rst_cnt[i] > 0) begin
      reset_s[i] = 1'b1; rst_cnt[i]--; clear_model(i);
    end else if (reset_s[i]) begin
      reset_s[i] = 1'b0; just_reset[i] = 1'b1; clear_model(i);
    end
    if (reset_s[i]) begin
      start_s[i] = 1'b0; stall_s[i] = 1'b0; rdv_s[i] = 1'b0;
      return;
    end
    if (start_pending[i]) begin
      start_pending[i] = 1'b0;
      push_frame(i);
    end
    start_s[i] = 1'b0;
    if (go_req[i] && model_idle(i)) begin
      start_s[i] = 1'b1; start_pending[i] = 1'b1; go_req[i] = 1'b0;
    end else if (spur_en[i] && !model_idle(i) && $urandom_range(3) == 0) begin
      start_s[i] = 1'b1;
    end
    rdv_s[i] = 1'b0;
    if (kick_rdv[i]) begin
      rdv_s[i] = 1'b1; kick_rdv[i] = 1'b0;
    end else if (req_s[i]) begin
      if (hold_addr[i] >= 0 && addr_s[i] == AW'(hold_addr[i])) begin
        wait_cnt[i] = 0;
      end else if (wait_cnt[i] >= lat[i]) begin
        rdv_s[i] = 1'b1; wait_cnt[i] = 0;
      end else begin
        wait_cnt[i]++;
      end
    end else begin
      wait_cnt[i] = 0;
      if (spur_en[i] && pend_shift[i] > 0 && $urandom_range(2) == 0) rdv_s[i] = 1'b1;
    end
    stall_s[i] = 1'b0;
    if (stall_w0[i] && words_loaded[i] == 1 && pend_shift[i] == BEATS - 1 && stall_run[i] < 3) begin
      stall_s[i] = 1'b1; stall_run[i]++;
    end else if (stall_prob[i] > 0 && $urandom_range(99) < stall_prob[i]) begin
      stall_s[i] = 1'b1;
    end
    if (stall_s[i] && pend_shift[i] > 0) stall_cnt[i]++;
  endtask

  // Monitor: compare the settled outputs of one instance with the scoreboard.
  task automatic mon(int i);
    int  idx;
    ev_t ev;
    if (reset_s[i]) return;
    if (just_reset[i]) begin
      just_reset[i] = 1'b0;
      check("reset_addr", addr_s[i], start_cfg[i]);
    end
    if (req_s[i] && req_prev[i]) check("addr_stable", addr_s[i], addr_prev[i]);
    req_run[i]   = req_s[i] ? req_run[i] + 1 : 0;
    req_prev[i]  = req_s[i];
    addr_prev[i] = addr_s[i];
    idx = front_idx(i);
    if (idx < 0) begin
      check("idle_outputs", {req_s[i], load_s[i], shift_s[i], win_s[i], row_s[i], busy_s[i], done_s[i]}, 0);
      return;
    end
    ev = exp_q[idx];
    check("busy", busy_s[i], ev.kind != K_DONE);
    check("stray_flags", {win_s[i] & ~shift_s[i], row_s[i] & ~load_s[i], load_s[i] & ~req_s[i], shift_s[i] & req_s[i]}, 0);
    if (pend_shift[i] > 0) check("shift_vs_stall", shift_s[i], !stall_s[i]);
    else check("no_shift_outside_beats", shift_s[i], 0);
    if (ev.kind == K_DONE) check("done_pulse", done_s[i], 1);
    if (load_s[i]) begin
      check("load_expected", ev.kind, K_LOAD);
      if (ev.kind == K_LOAD) begin
        check("load_addr", addr_s[i], ev.addr);
        check("row_start", row_s[i], ev.row);
        check("req_hold_cycles", req_run[i], lat[i] + 1);
        check("load_time", cyc - t_start[i], words_loaded[i] * (lat[i] + 1 + BEATS) + stall_cnt[i] + lat[i]);
        exp_q.delete(idx); words_loaded[i]++; pend_shift[i] = BEATS;
      end
    end else if (shift_s[i]) begin
      check("shift_expected", ev.kind, K_SHIFT);
      if (ev.kind == K_SHIFT) begin
        check("window_valid", win_s[i], ev.win);
        exp_q.delete(idx); pend_shift[i]--;
      end
    end else if (done_s[i]) begin
      check("done_expected", ev.kind, K_DONE);
      if (ev.kind == K_DONE) begin
        check("frame_length", cyc - t_start[i], words_loaded[i] * (lat[i] + 1 + BEATS) + stall_cnt[i]);
        exp_q.delete(idx);
      end
    end
  endtask

  always @(negedge clk) begin
    #1;
    for (int i = 0; i < NI; i++) mon(i);
  end

  task automatic cycle();
    @(negedge clk);
    drive(0);
    drive(1);
  endtask

  task automatic run_frame(int i);
    bit ok = 1'b0;
    go_req[i] = 1'b1;
    repeat (2) cycle();
    for (int n = 0; n < 3000; n++) begin
      #2;
      if (model_idle(i)) begin ok = 1'b1; break; end
      cycle();
    end
    if (!ok) begin
      check("frame_timeout", 0, 1);
      rst_cnt[i] = 1;
      repeat (3) cycle();
    end
  endtask

  initial begin
    bit found = 1'b0;
    for (int i = 0; i < NI; i++) begin
      hold_addr[i] = -1; rst_cnt[i] = 2; lat[i] = 0;
    end
    reset_s = '1; start_s = '0; stall_s = '0; rdv_s = '0;
    repeat (5) cycle();

    // Baseline frame, one-cycle memory wait
    lat[0] = 1; run_frame(0);
    // Slow memory
    lat[0] = 5; run_frame(0);
    // Stall during beat 1 of word 0
    lat[0] = 0; stall_w0[0] = 1'b1; run_frame(0); stall_w0[0] = 1'b0;
    repeat (2) cycle();

    // Reset while waiting on the read of address 2, then a late rd_valid_i
    hold_addr[0] = 2; go_req[0] = 1'b1;
    for (int n = 0; n < 200; n++) begin
      cycle(); #2;
      if (req_s[0] && addr_s[0] == AW'(2)) begin found = 1'b1; break; end
    end
    check("reached_fetch_addr2", found, 1);
    repeat (3) cycle();
    rst_cnt[0] = 1; cycle();
    kick_rdv[0] = 1'b1; hold_addr[0] = -1; cycle();
    repeat (3) cycle();
    run_frame(0);

    // Randomized frames with spurious start/rd_valid and random stalls
    for (int k = 0; k < 6; k++) begin
      lat[0] = $urandom_range(3); stall_prob[0] = $urandom_range(40); spur_en[0] = 1'b1;
      run_frame(0);
    end
    spur_en[0] = 1'b0; stall_prob[0] = 0;

    // Single-word frame
    lat[1] = 0; run_frame(1);
    for (int k = 0; k < 3; k++) begin
      lat[1] = $urandom_range(2); stall_prob[1] = $urandom_range(50); spur_en[1] = 1'b1;
      run_frame(1);
    end
    spur_en[1] = 1'b0; stall_prob[1] = 0;
    repeat (4) cycle();
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
